// File: rtl/lane_serializer_pkg.sv
// lane_serializer_pkg: Aurora TX symbol types, serializer constants and PRBS7 step helper
package lane_serializer_pkg;
  localparam int MAX_LINKS = 4;
  localparam int ENCODED_DATA_SIZE = 10;
  localparam int SER_FIFO_DEPTH = 4;
  localparam int PRBS_W = 7;
  typedef logic [ENCODED_DATA_SIZE-1:0] symbol_t;
  typedef symbol_t [MAX_LINKS-1:0] bonded_sym_t;
  localparam symbol_t K28_5_RDN = 10'h17C;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h7F;
  function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction
endpackage

// File: rtl/lane_serializer_sym_fifo.sv
// sym_fifo: synchronous FIFO with occupancy output and no read bypass
module sym_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && level_q != FULL;
    do_pop = pop && level_q != '0;
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
    mem_q <= mem_d;
  end
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
endmodule

// File: rtl/lane_serializer.sv
// lane_serializer: buffers bonded symbols and shifts each lane out LSB first; LANE_SERIALIZER_PRBS_EN adds a PRBS7 load mode
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int LANES = MAX_LINKS,
  parameter int SYM_W = ENCODED_DATA_SIZE,
  parameter int FIFO_DEPTH = SER_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0][SYM_W-1:0]   sym_in,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic [LANES-1:0]              lane_en,
  input  logic [SYM_W-1:0]              idle_sym,
`ifdef LANE_SERIALIZER_PRBS_EN
  input  logic                          prbs_mode,
`endif
  output logic [LANES-1:0]              serial_out,
  output logic                          sym_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt
);
  localparam int CW = $clog2(SYM_W);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(SYM_W - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  logic [LANES-1:0][SYM_W-1:0] shreg_q, shreg_d, load_val, fifo_rdata, prbs_sym;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [LANES-1:0] serial_q, serial_d;
  logic strobe_q, strobe_d, started_q, started_d;
  logic [15:0] underrun_q, underrun_d;
  logic load, push, pop, empty, prbs_load;
  sym_fifo #(.WIDTH(LANES * SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(sym_in),
    .pop(pop),
    .rdata(fifo_rdata),
    .level(fifo_level)
  );
`ifdef LANE_SERIALIZER_PRBS_EN
  logic [LANES-1:0][PRBS_W-1:0] lfsr_q, lfsr_d;
  assign prbs_load = load && prbs_mode;
  always_comb begin
    lfsr_d = lfsr_q;
    prbs_sym = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < SYM_W; b++) begin
        lfsr_d[l] = prbs7_next(lfsr_d[l]);
        prbs_sym[l][b] = lfsr_d[l][0];
      end
    end
    if (!prbs_load) lfsr_d = lfsr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= {LANES{PRBS_SEED}};
    else lfsr_q <= lfsr_d;
  end
`else
  assign prbs_load = 1'b0;
  assign prbs_sym = '0;
`endif
  assign load = bit_cnt_q == LAST;
  assign empty = fifo_level == '0;
  assign sym_ready = !rst && fifo_level != FULL;
  assign push = sym_valid && sym_ready;
  assign pop = load && !empty && !prbs_load;
  always_comb begin
    load_val = prbs_load ? prbs_sym : empty ? {LANES{idle_sym}} : fifo_rdata;
    bit_cnt_d = load ? '0 : bit_cnt_q + CW'(1);
    shreg_d = shreg_q;
    serial_d = '0;
    for (int l = 0; l < LANES; l++) begin
      shreg_d[l] = load ? load_val[l] : shreg_q[l] >> 1;
      serial_d[l] = shreg_d[l][0] & lane_en[l];
    end
    strobe_d = load;
    started_d = started_q | pop;
    underrun_d = underrun_q + 16'(load && empty && !prbs_load && started_q && underrun_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bit_cnt_q <= LAST;
      serial_q <= '0;
      strobe_q <= 1'b0;
      started_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q <= serial_d;
      strobe_q <= strobe_d;
      started_q <= started_d;
      underrun_q <= underrun_d;
    end
  end
  assign serial_out = serial_q;
  assign sym_strobe = strobe_q;
  assign underrun_cnt = underrun_q;
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: random traffic against a symbol-level reference model plus literal scenario pins
module tb_lane_serializer;
  import lane_serializer_pkg::*;
  localparam int L = 4;
  localparam int W = 10;
  localparam int D = 4;
  typedef logic [L-1:0][W-1:0] word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sym_valid = 1'b0;
  word_t sym_in = '0;
  logic [L-1:0] lane_en = '1;
  logic [W-1:0] idle_sym = K28_5_RDN;
  logic sym_ready, sym_strobe;
  logic [L-1:0] serial_out;
  logic [2:0] fifo_level;
  logic [15:0] underrun_cnt;
  int errors = 0;
  int checks = 0;
  word_t mq[$];
  word_t cur;
  int phase;
  bit started, armed, m_acc;
  logic [15:0] m_under;
  logic [L-1:0] m_ser;
  logic m_strobe;

  lane_serializer dut (
    .clk(clk),
    .rst(rst),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .lane_en(lane_en),
    .idle_sym(idle_sym),
    .serial_out(serial_out),
    .sym_strobe(sym_strobe),
    .fifo_level(fifo_level),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: a symbol slot opens every W cycles after reset release; each slot takes the
  // oldest word accepted in an earlier cycle, else the idle symbol.
  always @(negedge clk) begin
    if (armed) begin
      chk("serial_out", serial_out, m_ser);
      chk("sym_strobe", sym_strobe, m_strobe);
      chk("fifo_level", fifo_level, mq.size());
      chk("sym_ready", sym_ready, !rst && mq.size() != D);
      chk("underrun_cnt", underrun_cnt, m_under);
    end
    if (rst) begin
      mq.delete();
      cur = '0;
      phase = W - 1;
      started = 0;
      m_under = '0;
      m_ser = '0;
      m_strobe = 1'b0;
      armed = 1;
    end else begin
      m_acc = sym_valid && mq.size() != D;
      if (phase == W - 1) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          started = 1;
        end else begin
          for (int i = 0; i < L; i++) cur[i] = idle_sym;
          if (started && m_under != 16'hFFFF) m_under++;
        end
        phase = 0;
      end else phase++;
      m_strobe = phase == 0;
      for (int i = 0; i < L; i++) m_ser[i] = cur[i][phase] & lane_en[i];
      if (m_acc) mq.push_back(sym_in);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < L; i++) w[i] = 10'($urandom);
    return w;
  endfunction

  task automatic wait_strobe(input string name);
    bit found = 0;
    for (int i = 0; i < 2 * W && !found; i++) begin
      step();
      found = sym_strobe;
    end
    if (!found) chk(name, 0, 1);
  endtask

  task automatic idle_restart(input string tag);
    word_t got = '0;
    rst = 1'b1;
    sym_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk({tag, "_strobe_pre"}, sym_strobe, 0);
    step();
    chk({tag, "_strobe_first"}, sym_strobe, 1);
    for (int i = 0; i < 3 * W; i++) begin
      for (int l = 0; l < L; l++) got[l][i % W] = serial_out[l];
      if (i % W == W - 1)
        for (int l = 0; l < L; l++) chk({tag, "_idle_pattern"}, got[l], 10'h17C);
      step();
    end
    chk({tag, "_underrun_zero"}, underrun_cnt, 0);
  endtask

  initial begin
    word_t got;
    bit seen_full, want4, done43, found;
    int bad, ones02;
    idle_restart("s1");
    sym_in = rand_word();
    sym_in[0] = 10'h3FF;
    sym_in[1] = 10'h001;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    wait_strobe("s2_strobe_wait");
    got = '0;
    for (int i = 0; i < W; i++) begin
      for (int l = 0; l < L; l++) got[l][i] = serial_out[l];
      step();
    end
    chk("s2_lane0_ones", got[0], 10'h3FF);
    chk("s2_lane1_single", got[1], 10'h001);
    chk("s2_next_strobe", sym_strobe, 1);
    chk("s2_underrun_one", underrun_cnt, 1);
    sym_valid = 1'b1;
    seen_full = 0;
    want4 = 0;
    done43 = 0;
    for (int i = 0; i < 80; i++) begin
      sym_in = rand_word();
      step();
      if (want4) begin
        chk("s4_refill", fifo_level, 4);
        want4 = 0;
      end
      if (fifo_level == 3'd4) begin
        if (!seen_full) chk("s3_ready_full", sym_ready, 0);
        seen_full = 1;
      end
      if (seen_full && sym_strobe && !done43) begin
        chk("s4_pop_no_push", fifo_level, 3);
        want4 = 1;
        done43 = 1;
      end
    end
    chk("s3_reached_full", seen_full, 1);
    lane_en = 4'b0101;
    step();
    bad = 0;
    ones02 = 0;
    for (int i = 0; i < 60; i++) begin
      sym_valid = 1'($urandom_range(0, 1));
      sym_in = rand_word();
      step();
      if (serial_out[1] || serial_out[3]) bad++;
      ones02 += int'(serial_out[0]) + int'(serial_out[2]);
    end
    chk("s5_lanes13_zero", bad, 0);
    chk("s5_lanes02_active", ones02 != 0, 1);
    lane_en = '1;
    sym_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = fifo_level == 3'd0;
    end
    if (!found) chk("s6_drain_wait", 0, 1);
    wait_strobe("s6_strobe_wait");
    for (int i = 0; i < 3; i++) begin
      sym_in = rand_word();
      sym_valid = 1'b1;
      step();
    end
    sym_valid = 1'b0;
    step();
    chk("s6_queued", fifo_level, 3);
    rst = 1'b1;
    step();
    chk("s6_rst_serial", serial_out, 0);
    chk("s6_rst_level", fifo_level, 0);
    chk("s6_rst_strobe", sym_strobe, 0);
    idle_restart("s6");
    for (int i = 0; i < 200; i++) begin
      sym_valid = 1'($urandom_range(0, 3) != 0);
      sym_in = rand_word();
      lane_en = 4'($urandom);
      if (i % 37 == 0) idle_sym = 10'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
